// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner.
// Contents:
//   HEX_FONT    - 16-entry hex font, active-high, bit order {g,f,e,d,c,b,a}
//   SEG_OFF     - glyph with every segment dark (active-high)
//   counterWidth - bit width for a counter that must hold 0..n-1, at least 1
package seg_pkg;

  // Index 0 is the glyph for hex 0. The list is written from F down to 0
  // because the leftmost element of a packed array is the highest index.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71,  // F
    7'h79,  // E
    7'h5E,  // d
    7'h39,  // C
    7'h7C,  // b
    7'h77,  // A
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

  localparam logic [6:0] SEG_OFF = 7'h00;

  // $clog2 returns 0 for n <= 1, but every counter needs at least one bit.
  function automatic int counterWidth(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Hex nibble to seven-segment glyph, purely combinational.
// Ports:
//   i_nibble - 4-bit hex value
//   o_glyph  - active-high segments {g,f,e,d,c,b,a}
// Output polarity is the caller's business.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_glyph
);

  assign o_glyph = HEX_FONT[i_nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment display driver.
// Scans DIGITS hex digits, DIV clock cycles per digit. The display value is
// captured once per frame so a frame never mixes old and new digits.
// Ports:
//   clk_in      - system clock
//   rstn_in     - synchronous active-low reset
//   val_in      - hex nibbles, bits [3:0] belong to digit 0 (rightmost)
//   dp_in       - decimal-point request per digit
//   digit_en_in - per-digit enable, 0 keeps the digit dark
//   blank_lz_in - 1 blanks leading zeros (digit 0 is never blanked)
//   bright_in   - brightness, duty = (bright_in+1)/2^DIM_BITS
//   cat_out     - segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   dp_out      - decimal-point segment, polarity per SEG_ACTIVE_LOW
//   an_out      - digit select, one-hot in the polarity given by AN_ACTIVE_LOW
//   frame_out   - one-cycle pulse after a new frame's values were latched
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int DIV            = 200000,
  parameter int DIM_BITS       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  rstn_in,
  input  logic [4*DIGITS-1:0]   val_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en_in,
  input  logic                  blank_lz_in,
  input  logic [DIM_BITS-1:0]   bright_in,
  output logic [6:0]            cat_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_out
);

  localparam int CNT_W = counterWidth(DIV);
  localparam int IDX_W = counterWidth(DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Pin levels for "nothing lit", with polarity applied.
  localparam logic [DIGITS-1:0] AN_IDLE  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [6:0]        CAT_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic              DP_IDLE  = SEG_ACTIVE_LOW;

  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [DIM_BITS-1:0] r_pwm;

  logic [4*DIGITS-1:0] r_valSh;
  logic [DIGITS-1:0]   r_dpSh;
  logic [DIGITS-1:0]   r_enSh;
  logic                r_blankLzSh;
  logic [DIM_BITS-1:0] r_brightSh;

  logic [6:0]          r_cat;
  logic                r_dp;
  logic [DIGITS-1:0]   r_an;
  logic                r_frame;

  logic                w_slotEnd;
  logic                w_frameStart;
  logic [3:0]          w_nibble;
  logic [6:0]          w_glyph;
  logic [DIGITS-1:0]   w_blank;
  logic                w_zeroRun;
  logic [DIM_BITS-1:0] w_brightInv;
  logic                w_lit;
  logic [6:0]          w_segOn;
  logic [6:0]          w_catNext;
  logic                w_dpNext;
  logic [DIGITS-1:0]   w_anNext;

  assign w_slotEnd    = (r_cnt == CNT_LAST);
  assign w_frameStart = (r_cnt == '0) && (r_idx == '0);

  // Slot/digit/PWM counters, frame-start shadow capture and registered pins.
  // The PWM counter restarts with each slot so every digit sees the same
  // on/off pattern; the shadows only ever change at the very start of a frame.
  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_pwm       <= '0;
      r_valSh     <= '0;
      r_dpSh      <= '0;
      r_enSh      <= '0;
      r_blankLzSh <= 1'b0;
      r_brightSh  <= '0;
      r_cat       <= CAT_IDLE;
      r_dp        <= DP_IDLE;
      r_an        <= AN_IDLE;
      r_frame     <= 1'b0;
    end else begin
      if (w_slotEnd) begin
        r_cnt <= '0;
        r_pwm <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_pwm <= r_pwm + DIM_BITS'(1);
      end

      if (w_frameStart) begin
        r_valSh     <= val_in;
        r_dpSh      <= dp_in;
        r_enSh      <= digit_en_in;
        r_blankLzSh <= blank_lz_in;
        r_brightSh  <= bright_in;
      end

      r_cat   <= w_catNext;
      r_dp    <= w_dpNext;
      r_an    <= w_anNext;
      r_frame <= w_frameStart;
    end
  end

  assign w_nibble = r_valSh[{r_idx, 2'b00} +: 4];

  seg_hex_decoder u_decoder (
    .i_nibble (w_nibble),
    .o_glyph  (w_glyph)
  );

  // Leading-zero mask: walk from the most significant digit down, keeping
  // a running "everything so far is zero" flag. Digit 0 is never visited,
  // so a value of zero still shows a single "0".
  always_comb begin
    w_blank   = '0;
    w_zeroRun = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      w_zeroRun  = w_zeroRun & (r_valSh[4*k +: 4] == 4'h0);
      w_blank[k] = r_blankLzSh & w_zeroRun;
    end
  end

  // A digit lights only when enabled, outside the guard cycle at the start of
  // its slot, and in the upper part of the PWM ramp; a larger brightness
  // lowers the threshold and widens the on-time.
  assign w_brightInv = ~r_brightSh;
  assign w_lit       = r_enSh[r_idx] && (r_cnt != '0) && (r_pwm >= w_brightInv);
  assign w_segOn     = w_blank[r_idx] ? SEG_OFF : w_glyph;

  // Next pin values with polarity applied; a blanked digit still shows its dp.
  always_comb begin
    w_catNext = CAT_IDLE;
    w_dpNext  = DP_IDLE;
    w_anNext  = AN_IDLE;
    if (w_lit) begin
      w_catNext = SEG_ACTIVE_LOW ? ~w_segOn : w_segOn;
      w_dpNext  = SEG_ACTIVE_LOW ? ~r_dpSh[r_idx] : r_dpSh[r_idx];
      w_anNext  = AN_ACTIVE_LOW ? ~(DIGITS'(1) << r_idx) : (DIGITS'(1) << r_idx);
    end
  end

  assign cat_out   = r_cat;
  assign dp_out    = r_dp;
  assign an_out    = r_an;
  assign frame_out = r_frame;

endmodule
